// File: rtl/vgm_wb_master_checker_pkg.sv
// Shared definitions for the Wishbone B4 classic master-side checker:
// rule numbering, rule count and a popcount helper used to add the number
// of rules that fired on one edge to the violation counter.
package vgm_wb_checker_pkg;

   localparam int NUM_RULES = 5;
   localparam int POP_WIDTH = $clog2(NUM_RULES + 1);

   // Bit position of each rule in ERR / ERR_STICKY.
   typedef enum logic [2:0] {
      RULE_STB_WITHOUT_CYC = 3'd0,
      RULE_STB_DROPPED     = 3'd1,
      RULE_ADR_CHANGED     = 3'd2,
      RULE_CYC_DROPPED     = 3'd3,
      RULE_ACK_UNEXPECTED  = 3'd4
   } rule_e;

   // Number of set bits in a rule vector.
   function automatic logic [POP_WIDTH-1:0] popcount(input logic [NUM_RULES-1:0] v);
      logic [POP_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_RULES; i++) begin
         n = n + POP_WIDTH'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/vgm_wb_master_checker_if.sv
// Wishbone B4 classic request/acknowledge signals between a master and its
// slave. The checker only observes, so it uses the all-input monitor view.
// Handshake: a transfer is requested while CYC & STB are high and completes
// on the edge where ACK is also sampled high; until then STB, CYC and ADR
// must stay stable.
interface vgm_wb_master_checker_if #(
   parameter int ADR_WIDTH = 32
);
   logic                 CYC;
   logic                 STB;
   logic [ADR_WIDTH-1:0] ADR;
   logic                 ACK;

   modport master  (output CYC, output STB, output ADR, input  ACK);
   modport slave   (input  CYC, input  STB, input  ADR, output ACK);
   modport monitor (input  CYC, input  STB, input  ADR, input  ACK);
endinterface

// File: rtl/vgm_wb_master_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low clear and a variable
// increment amount. Sticks at all-ones instead of wrapping.
// INC_WIDTH must not exceed WIDTH + 1.
module vgm_sat_counter #(
   parameter int WIDTH     = 16,
   parameter int INC_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [INC_WIDTH-1:0] inc,
   output logic [WIDTH-1:0]     count
);

   localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] count_nxt;

   // One extra bit of headroom exposes overflow, which is clamped to max.
   always_comb begin
      sum       = {1'b0, count} + (WIDTH + 1)'(inc);
      count_nxt = (sum > MAX_EXT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/vgm_wb_master_checker.sv
// Passive protocol checker for the master side of a Wishbone B4 classic bus.
// Each rule violation produces a one-cycle ERR pulse, a sticky flag and adds
// to a saturating violation count; completed transfers are counted too.
// All outputs are registered, so there is no input-to-output comb path.
// Build option: define VGM_WB_CHECKER_SVA_EN to compile concurrent assertions
// (one per rule) and covers for plain and wait-state transfers.
module vgm_wb_master_checker
   import vgm_wb_checker_pkg::*;
#(
   parameter int ADR_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   vgm_wb_master_checker_if.monitor bus,
   output logic [NUM_RULES-1:0]    ERR,
   output logic [NUM_RULES-1:0]    ERR_STICKY,
   output logic [CNT_WIDTH-1:0]    ERR_CNT,
   output logic [CNT_WIDTH-1:0]    XFER_CNT
);

   // A request issued on the previous edge that was not acknowledged there.
   logic                 pending;
   logic [ADR_WIDTH-1:0] adr_q;

   logic [NUM_RULES-1:0] fired;
   logic [POP_WIDTH-1:0] fired_cnt;
   logic                 xfer;

   // Rule evaluation on the current sample against the previous-edge state.
   always_comb begin
      fired = '0;
      fired[RULE_STB_WITHOUT_CYC] = bus.STB & ~bus.CYC;
      fired[RULE_STB_DROPPED]     = pending & ~bus.STB;
      fired[RULE_ADR_CHANGED]     = pending & bus.STB & (bus.ADR != adr_q);
      fired[RULE_CYC_DROPPED]     = pending & ~bus.CYC;
      fired[RULE_ACK_UNEXPECTED]  = bus.ACK & ~(bus.CYC & bus.STB);
      fired_cnt = popcount(fired);
      xfer      = bus.CYC & bus.STB & bus.ACK;
   end

   // Outstanding-request tracking and registered violation flags.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         pending    <= 1'b0;
         adr_q      <= '0;
         ERR        <= '0;
         ERR_STICKY <= '0;
      end else begin
         pending    <= bus.CYC & bus.STB & ~bus.ACK;
         adr_q      <= bus.ADR;
         ERR        <= fired;
         ERR_STICKY <= ERR_STICKY | fired;
      end
   end

   vgm_sat_counter #(
      .WIDTH     (CNT_WIDTH),
      .INC_WIDTH (POP_WIDTH)
   ) u_err_cnt (
      .clk   (CLK),
      .clr_n (RST),
      .inc   (fired_cnt),
      .count (ERR_CNT)
   );

   vgm_sat_counter #(
      .WIDTH     (CNT_WIDTH),
      .INC_WIDTH (1)
   ) u_xfer_cnt (
      .clk   (CLK),
      .clr_n (RST),
      .inc   (xfer),
      .count (XFER_CNT)
   );

`ifdef VGM_WB_CHECKER_SVA_EN
   // The rules restated as properties; pending/adr_q carry the history so the
   // first edge after reset behaves exactly like the flag logic.
   a_r0_stb_without_cyc: assert property (@(posedge CLK) disable iff (!RST)
      !(bus.STB && !bus.CYC))
      else $error("R0 stb_without_cyc");
   a_r1_stb_dropped: assert property (@(posedge CLK) disable iff (!RST)
      !(pending && !bus.STB))
      else $error("R1 stb_dropped");
   a_r2_adr_changed: assert property (@(posedge CLK) disable iff (!RST)
      !(pending && bus.STB && (bus.ADR != adr_q)))
      else $error("R2 adr_changed");
   a_r3_cyc_dropped: assert property (@(posedge CLK) disable iff (!RST)
      !(pending && !bus.CYC))
      else $error("R3 cyc_dropped");
   a_r4_ack_unexpected: assert property (@(posedge CLK) disable iff (!RST)
      !(bus.ACK && !(bus.CYC && bus.STB)))
      else $error("R4 ack_unexpected");

   c_xfer: cover property (@(posedge CLK) disable iff (!RST)
      bus.CYC && bus.STB && bus.ACK);
   c_wait_xfer: cover property (@(posedge CLK) disable iff (!RST)
      (bus.CYC && bus.STB && !bus.ACK) [*1:$] ##1 (bus.CYC && bus.STB && bus.ACK));
`endif

endmodule

// File: tb/tb_vgm_wb_master_checker.sv
// Directed and randomized bench for vgm_wb_master_checker (CNT_WIDTH = 4 so
// counter saturation is reachable). A transaction-level reference model
// tracks the outstanding request and the expected flags/counters.
module tb_vgm_wb_master_checker;
   import vgm_wb_checker_pkg::*;

   localparam int AW      = 32;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          CLK;
   logic          RST;
   logic [4:0]    ERR;
   logic [4:0]    ERR_STICKY;
   logic [CW-1:0] ERR_CNT;
   logic [CW-1:0] XFER_CNT;

   vgm_wb_master_checker_if #(.ADR_WIDTH(AW)) bus_if ();

   vgm_wb_master_checker #(
      .ADR_WIDTH (AW),
      .CNT_WIDTH (CW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus_if),
      .ERR        (ERR),
      .ERR_STICKY (ERR_STICKY),
      .ERR_CNT    (ERR_CNT),
      .XFER_CNT   (XFER_CNT)
   );

   // Clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   bit          m_outstanding;
   logic [31:0] m_req_adr;
   logic [4:0]  m_err;
   logic [4:0]  m_sticky;
   int          m_err_cnt;
   int          m_xfer_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outcome of one clock edge, from the bus rules.
   task automatic model_edge(input logic rst, input logic cyc, input logic stb,
                             input logic [31:0] adr, input logic ack);
      logic [4:0] v;
      if (!rst) begin
         m_outstanding = 0;
         m_req_adr     = '0;
         m_err         = '0;
         m_sticky      = '0;
         m_err_cnt     = 0;
         m_xfer_cnt    = 0;
      end else begin
         v    = '0;
         v[0] = stb && !cyc;
         v[1] = m_outstanding && !stb;
         v[2] = m_outstanding && stb && (adr != m_req_adr);
         v[3] = m_outstanding && !cyc;
         v[4] = ack && !(cyc && stb);
         m_err      = v;
         m_sticky   = m_sticky | v;
         m_err_cnt  = m_err_cnt + $countones(v);
         if (m_err_cnt > CNT_MAX) m_err_cnt = CNT_MAX;
         if (cyc && stb && ack && m_xfer_cnt < CNT_MAX) m_xfer_cnt++;
         m_outstanding = cyc && stb && !ack;
         m_req_adr     = adr;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".err"},    32'(ERR),        32'(m_err));
      chk({tag, ".sticky"}, 32'(ERR_STICKY), 32'(m_sticky));
      chk({tag, ".errcnt"}, 32'(ERR_CNT),    32'(m_err_cnt));
      chk({tag, ".xfer"},   32'(XFER_CNT),   32'(m_xfer_cnt));
   endtask

   // Driver: apply one bus sample, let one edge pass, check #1 later.
   task automatic step(input string tag, input logic rst, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic ack);
      RST        = rst;
      bus_if.CYC = cyc;
      bus_if.STB = stb;
      bus_if.ADR = adr;
      bus_if.ACK = ack;
      @(posedge CLK);
      model_edge(rst, cyc, stb, adr, ack);
      #1;
      check_model(tag);
   endtask

   initial begin
      logic        r_rst, r_cyc, r_stb, r_ack;
      logic [31:0] r_adr;

      // Reset state.
      step("reset0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step("reset1", 1'b0, 1'b1, 1'b1, 32'h44, 1'b1);
      chk("reset_err", 32'(ERR), 32'h0);
      chk("reset_cnt", 32'(ERR_CNT), 32'h0);

      // Clean single read, ACK on the third cycle.
      step("read_w1", 1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
      step("read_w2", 1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
      step("read_ack", 1'b1, 1'b1, 1'b1, 32'h10, 1'b1);
      step("read_idle", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("read_xfer", 32'(XFER_CNT), 32'd1);
      chk("read_errcnt", 32'(ERR_CNT), 32'd0);
      chk("read_sticky", 32'(ERR_STICKY), 32'h0);

      // STB without CYC for one edge.
      step("r0_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step("r0_hit", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("r0_err", 32'(ERR), 32'h01);
      chk("r0_cnt", 32'(ERR_CNT), 32'd1);
      step("r0_idle", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("r0_pulse_end", 32'(ERR), 32'h00);
      chk("r0_sticky", 32'(ERR_STICKY), 32'h01);

      // Address change while pending.
      step("r2_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step("r2_req", 1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
      step("r2_hit", 1'b1, 1'b1, 1'b1, 32'h24, 1'b0);
      chk("r2_err", 32'(ERR), 32'h04);
      step("r2_ack", 1'b1, 1'b1, 1'b1, 32'h24, 1'b1);
      chk("r2_xfer", 32'(XFER_CNT), 32'd1);

      // Address change with STB dropped on the same edge: only R1.
      step("r1_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step("r1_req", 1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
      step("r1_hit", 1'b1, 1'b1, 1'b0, 32'h24, 1'b0);
      chk("r1_err", 32'(ERR), 32'h02);
      chk("r1_cnt", 32'(ERR_CNT), 32'd1);

      // CYC and STB both dropped before ACK.
      step("r13_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step("r13_req", 1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
      step("r13_hit", 1'b1, 1'b0, 1'b0, 32'h20, 1'b0);
      chk("r13_err", 32'(ERR), 32'h0a);
      chk("r13_cnt", 32'(ERR_CNT), 32'd2);

      // ACK without STB, then reset.
      step("r4_hit", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("r4_err", 32'(ERR), 32'h10);
      chk("r4_cnt", 32'(ERR_CNT), 32'd3);
      step("r4_rst", 1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
      chk("r4_rst_sticky", 32'(ERR_STICKY), 32'h0);
      chk("r4_rst_cnt", 32'(ERR_CNT), 32'h0);
      // Request in flight across the reset is not checked.
      step("post_rst", 1'b1, 1'b1, 1'b1, 32'h34, 1'b0);
      chk("post_rst_err", 32'(ERR), 32'h0);

      // Back-to-back transfers until XFER_CNT saturates.
      step("sat_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         step("sat_b2b", 1'b1, 1'b1, 1'b1, 32'(i * 4), 1'b1);
      end
      chk("sat_xfer", 32'(XFER_CNT), 32'd15);
      chk("sat_sticky", 32'(ERR_STICKY), 32'h0);

      // Randomized traffic: mostly well-formed, with occasional violations.
      step("rnd_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      r_adr = 32'h0;
      for (int i = 0; i < 400; i++) begin
         r_rst = ($urandom_range(0, 39) != 0);
         r_cyc = ($urandom_range(0, 5) != 0);
         r_stb = ($urandom_range(0, 4) != 0);
         r_ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) r_adr = 32'($urandom_range(0, 3) * 4);
         step("rnd", r_rst, r_cyc, r_stb, r_adr, r_ack);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
